// File: rtl/mem_arbiter_rr.sv
// Arbitrates N cache ports onto one line-wide downstream port.
// Round-robin or fixed-priority; the grant is held until mem_resp.
module mem_arbiter_rr #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 256,
    parameter int unsigned MODE      = 0
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic [NUM_PORTS-1:0]                           req_read,
    input  logic [NUM_PORTS-1:0]                           req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]                    req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0]                    req_wdata,
    output logic [LINE_W-1:0]                              req_rdata,
    output logic [NUM_PORTS-1:0]                           req_resp,
    output logic                                           mem_read,
    output logic                                           mem_write,
    output logic [ADDR_W-1:0]                              mem_addr,
    output logic [LINE_W-1:0]                              mem_wdata,
    input  logic [LINE_W-1:0]                              mem_rdata,
    input  logic                                           mem_resp,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_id,
    output logic                                           busy
);

    localparam int unsigned ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [ID_W-1:0]     grant_nxt;
    logic                mem_read_nxt, mem_write_nxt, busy_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [LINE_W-1:0]   mem_wdata_nxt;

    logic [NUM_PORTS-1:0] pending;
    logic [ID_W-1:0]      win_lo, win_hi, win;
    logic                 any_pending, any_hi;
    logic [ADDR_W-1:0]    win_addr;
    logic [LINE_W-1:0]    win_wdata;
    logic                 win_write;

    // Winner: lowest pending index, or lowest at/above ptr with wrap in round-robin mode
    always_comb begin
        pending     = req_read | req_write;
        any_pending = |pending;
        win_lo      = '0;
        win_hi      = '0;
        any_hi      = 1'b0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_lo = ID_W'(i);
                if (i >= int'(ptr)) begin
                    win_hi = ID_W'(i);
                    any_hi = 1'b1;
                end
            end
        end
        if (MODE == 0 && any_hi) begin
            win = win_hi;
        end else begin
            win = win_lo;
        end
    end

    // Payload mux for the selected port
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (win == ID_W'(i)) begin
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[i*LINE_W +: LINE_W];
                win_write = req_write[i];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        grant_nxt     = grant_id;
        mem_read_nxt  = mem_read;
        mem_write_nxt = mem_write;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        case (state)
            S_IDLE: begin
                if (any_pending) begin
                    state_nxt     = S_BUSY;
                    grant_nxt     = win;
                    mem_addr_nxt  = win_addr;
                    mem_wdata_nxt = win_wdata;
                    mem_write_nxt = win_write;
                    mem_read_nxt  = ~win_write;
                end
            end
            S_BUSY: begin
                if (mem_resp) begin
                    state_nxt     = S_DONE;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    if (MODE == 0) begin
                        ptr_nxt = (grant_id == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + ID_W'(1);
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant_id  <= grant_nxt;
            mem_read  <= mem_read_nxt;
            mem_write <= mem_write_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
        end
    end

    // Completion is steered to the granted port in the same cycle as mem_resp
    always_comb begin
        req_resp = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            req_resp[i] = (state == S_BUSY) && mem_resp && (grant_id == ID_W'(i));
        end
    end

    assign req_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: per-cycle vector table on a 2-port
// round-robin instance, plus sequences on 4-port RR and 2-port fixed-priority instances.
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // ---- 2-port round-robin instance ----
    logic [1:0]   rd, wr;
    logic [31:0]  addr0, addr1;
    logic [255:0] wd0, wd1;
    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic [255:0] req_rdata;
    logic [1:0]   req_resp;
    logic         mem_read, mem_write, busy;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [0:0]   grant_id;

    mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(32), .LINE_W(256), .MODE(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_read(rd), .req_write(wr),
        .req_addr({addr1, addr0}), .req_wdata({wd1, wd0}),
        .req_rdata(req_rdata), .req_resp(req_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .grant_id(grant_id), .busy(busy)
    );

    // ---- 4-port round-robin instance ----
    logic [3:0]   rd4, resp4_out;
    logic         resp4, mrd4, mwr4, busy4;
    logic [31:0]  maddr4;
    logic [255:0] mwd4, rdata4;
    logic [1:0]   gid4;

    mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(32), .LINE_W(256), .MODE(0)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .req_read(rd4), .req_write(4'b0000),
        .req_addr({32'h300, 32'h200, 32'h100, 32'h000}), .req_wdata({4{256'h0}}),
        .req_rdata(rdata4), .req_resp(resp4_out),
        .mem_read(mrd4), .mem_write(mwr4),
        .mem_addr(maddr4), .mem_wdata(mwd4),
        .mem_rdata(256'h0), .mem_resp(resp4),
        .grant_id(gid4), .busy(busy4)
    );

    // ---- 2-port fixed-priority instance ----
    logic [1:0]   rdp, respp_out;
    logic         respp, mrdp, mwrp, busyp;
    logic [31:0]  maddrp;
    logic [255:0] mwdp, rdatap;
    logic [0:0]   gidp;

    mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(32), .LINE_W(256), .MODE(1)) dutp (
        .clk(clk), .reset_n(reset_n),
        .req_read(rdp), .req_write(2'b00),
        .req_addr({32'h1000, 32'h2000}), .req_wdata({2{256'h0}}),
        .req_rdata(rdatap), .req_resp(respp_out),
        .mem_read(mrdp), .mem_write(mwrp),
        .mem_addr(maddrp), .mem_wdata(mwdp),
        .mem_rdata(256'h0), .mem_resp(respp),
        .grant_id(gidp), .busy(busyp)
    );

    typedef struct {
        logic        rst_n;
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        resp;
        logic        e_rd;
        logic        e_wr;
        logic        e_busy;
        logic [1:0]  e_resp;
        logic        e_gid;
        logic [31:0] e_addr;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        rd        = 2'b00;
        wr        = 2'b00;
        mem_resp  = 1'b0;
        addr0     = 32'h0000_0080;
        addr1     = 32'h0000_1040;
        wd0       = 256'h1234;
        wd1       = 256'hBEEF;
        mem_rdata = {32{8'hA5}};
        rd4       = 4'b0000;
        resp4     = 1'b0;
        rdp       = 2'b00;
        respp     = 1'b0;

        //          rst   rd     wr     resp  e_rd  e_wr  busy  e_resp e_gid addr
        vecs[0]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h1040};
        vecs[3]  = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h1040};
        vecs[4]  = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h1040};
        vecs[5]  = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h1040};
        vecs[6]  = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 32'h1040};
        vecs[7]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h80};
        vecs[11] = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h1040};
        vecs[14] = '{1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 32'h1040};
        vecs[15] = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0};
        vecs[16] = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0};
        vecs[17] = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h80};
        vecs[18] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[19] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0};

        repeat (2) @(negedge clk);

        // Per-cycle table: drive at negedge, compare 1 time unit later
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset_n  = vecs[i].rst_n;
            rd       = vecs[i].rd;
            wr       = vecs[i].wr;
            mem_resp = vecs[i].resp;
            #1;
            check($sformatf("v%0d.mem_read", i),  64'(mem_read),  64'(vecs[i].e_rd));
            check($sformatf("v%0d.mem_write", i), 64'(mem_write), 64'(vecs[i].e_wr));
            check($sformatf("v%0d.busy", i),      64'(busy),      64'(vecs[i].e_busy));
            check($sformatf("v%0d.req_resp", i),  64'(req_resp),  64'(vecs[i].e_resp));
            check($sformatf("v%0d.grant_id", i),  64'(grant_id),  64'(vecs[i].e_gid));
            if (vecs[i].e_rd || vecs[i].e_wr || !vecs[i].rst_n)
                check($sformatf("v%0d.mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_addr));
            if (!vecs[i].rst_n)
                check_line($sformatf("v%0d.mem_wdata", i), mem_wdata, 256'h0);
            if (vecs[i].resp && vecs[i].e_busy)
                check_line($sformatf("v%0d.req_rdata", i), req_rdata, {32{8'hA5}});
        end

        // Requester changes its address/data while BUSY; latched values must hold
        @(negedge clk);
        wr = 2'b01; addr0 = 32'h80; wd0 = 256'h1234;
        @(negedge clk);
        addr0 = 32'hC0; wd0 = 256'hFFFF;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("hold%0d.mem_write", k), 64'(mem_write), 64'd1);
            check($sformatf("hold%0d.mem_addr", k),  64'(mem_addr),  64'h80);
            check_line($sformatf("hold%0d.mem_wdata", k), mem_wdata, 256'h1234);
            @(negedge clk);
        end
        mem_resp = 1'b1;
        #1;
        check("hold.req_resp", 64'(req_resp), 64'h1);
        check("hold.mem_addr_at_resp", 64'(mem_addr), 64'h80);
        @(negedge clk);
        mem_resp = 1'b0; wr = 2'b00;
        #1;
        check("hold.done_write", 64'(mem_write), 64'd0);
        check("hold.done_busy",  64'(busy),      64'd1);
        @(negedge clk);
        #1;
        check("hold.idle_busy", 64'(busy), 64'd0);

        // Async reset in the middle of a BUSY cycle, then a stray mem_resp
        @(negedge clk);
        rd = 2'b10;
        @(negedge clk);
        #1;
        check("arst.pre_read", 64'(mem_read), 64'd1);
        @(posedge clk);
        #3;
        mem_resp = 1'b1;
        reset_n  = 1'b0;
        #1;
        check("arst.mem_read", 64'(mem_read), 64'd0);
        check("arst.busy",     64'(busy),     64'd0);
        check("arst.req_resp", 64'(req_resp), 64'h0);
        check("arst.grant_id", 64'(grant_id), 64'h0);
        @(negedge clk);
        rd = 2'b00;
        reset_n = 1'b1;
        #1;
        check("arst.stray_resp", 64'(req_resp), 64'h0);
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        check("arst.post_busy", 64'(busy),     64'd0);
        check("arst.post_read", 64'(mem_read), 64'd0);

        // 4-port round-robin with all ports requesting continuously
        @(negedge clk);
        rd4 = 4'hF;
        for (int g = 0; g < 6; g++) begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                #1;
                seen = mrd4;
            end
            check($sformatf("rr4.g%0d.seen", g), 64'(seen), 64'd1);
            check($sformatf("rr4.g%0d.grant_id", g), 64'(gid4), 64'(g % 4));
            resp4 = 1'b1;
            #1;
            check($sformatf("rr4.g%0d.req_resp", g), 64'(resp4_out), 64'(4'b0001 << (g % 4)));
            @(negedge clk);
            resp4 = 1'b0;
        end
        rd4 = 4'h0;

        // Fixed priority: port 0 always wins over a continuously requesting port 1
        @(negedge clk);
        rdp = 2'b11;
        for (int g = 0; g < 4; g++) begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                #1;
                seen = mrdp;
            end
            check($sformatf("fp.g%0d.seen", g), 64'(seen), 64'd1);
            check($sformatf("fp.g%0d.grant_id", g), 64'(gidp), 64'd0);
            check($sformatf("fp.g%0d.mem_addr", g), 64'(maddrp), 64'h2000);
            respp = 1'b1;
            #1;
            check($sformatf("fp.g%0d.req_resp", g), 64'(respp_out), 64'h1);
            @(negedge clk);
            respp = 1'b0;
        end
        rdp = 2'b00;

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
